phase_ring_gen: RTL

- Parametrised N-phase ring generator. It produces one-hot, optionally non-overlapping phase strobes from a Johnson-coded ring.
- Successor to the fixed 4-phase ring counter. Adds:
  - configurable phase count
  - per-phase hold time
  - dead-time gap
  - up/down direction
  - synchronous phase load
  - illegal-state self-correction
- Drives phase-sequenced datapath enables downstream.

---
 rtl/phase_ring_pkg.sv | 69 ++++++
 rtl/phase_johnson_core.sv | 52 +++++
 rtl/phase_ring_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/phase_ring_pkg.sv
// phase_ring_pkg: shared types and Johnson-code helpers for phase_ring_gen.
// Helpers work on a max-width code vector; callers pass the live width j.
package phase_ring_pkg;

    typedef enum logic {
        ST_PHASE = 1'b0,
        ST_GAP   = 1'b1
    } state_t;

    localparam int MAX_J  = 16;
    localparam int MAX_N  = 2 * MAX_J;
    localparam int MAX_IW = $clog2(MAX_N);

    typedef logic [MAX_J-1:0] jcode_t;

    function automatic jcode_t jmask(input int j);
        jcode_t m;
        m = '0;
        for (int i = 0; i < MAX_J; i++) begin
            if (i < j) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Forward shifts ~msb in at the bottom; reverse shifts ~lsb in at the top.
    function automatic jcode_t johnson_next(input jcode_t code, input logic dir,
                                            input int j);
        jcode_t r;
        if (!dir) begin
            r    = code << 1;
            r[0] = ~code[j-1];
        end else begin
            r      = code >> 1;
            r[j-1] = ~code[0];
        end
        return r & jmask(j);
    endfunction

    // The single 0/1 boundary position plus the lsb identifies the phase.
    function automatic int johnson_to_idx(input jcode_t code, input int j);
        int b;
        b = 0;
        for (int i = 1; i < MAX_J; i++) begin
            if (i < j && b == 0 && code[i] != code[i-1]) b = i;
        end
        if (b == 0) return code[0] ? j : 0;
        return code[0] ? b : j + b;
    endfunction

    function automatic jcode_t idx_to_johnson(input int idx, input int j);
        jcode_t r;
        r = '0;
        for (int i = 0; i < MAX_J; i++) begin
            if (i < j) r[i] = (idx <= j) ? (i < idx) : (i >= idx - j);
        end
        return r;
    endfunction

    // Legal Johnson codes have at most one adjacent-bit transition.
    function automatic logic johnson_legal(input jcode_t code, input int j);
        int n;
        n = 0;
        for (int i = 1; i < MAX_J; i++) begin
            if (i < j && code[i] != code[i-1]) n++;
        end
        return n <= 1;
    endfunction

endpackage

// File: rtl/phase_johnson_core.sv
// phase_johnson_core: J-bit Johnson register with step/dir/load/clear.
// Exposes current and next decoded index plus a legality flag.
module phase_johnson_core
    import phase_ring_pkg::*;
#(
    parameter int J  = 2,
    parameter int IW = 2
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          step_i,
    input  logic          dir_i,
    input  logic          load_i,
    input  logic [IW-1:0] load_idx_i,
    output logic [IW-1:0] idx_o,
    output logic [IW-1:0] idx_nxt_o,
    output logic          legal_o
);

    logic [J-1:0] code_q;
    logic [J-1:0] code_d;
    jcode_t       code_w;
    jcode_t       nxt_w;

    // Widen the live code and pick the next code by priority.
    always_comb begin
        code_w        = '0;
        code_w[J-1:0] = code_q;
        legal_o       = johnson_legal(code_w, J);
        nxt_w         = code_w;
        if (!legal_o) begin
            nxt_w = '0;
        end else if (load_i) begin
            nxt_w = idx_to_johnson(int'(load_idx_i), J);
        end else if (step_i) begin
            nxt_w = johnson_next(code_w, dir_i, J);
        end
        code_d    = nxt_w[J-1:0];
        idx_o     = IW'(johnson_to_idx(code_w, J));
        idx_nxt_o = IW'(johnson_to_idx(nxt_w, J));
    end

    // Johnson code register; clear returns to phase 0.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            code_q <= '0;
        end else begin
            code_q <= code_d;
        end
    end

endmodule

// File: rtl/phase_ring_gen.sv
// phase_ring_gen: N-phase one-hot strobe generator with hold, dead-time gap,
// direction, load and illegal-code recovery around a Johnson ring.
module phase_ring_gen
    import phase_ring_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                          Phase_Count,
    input  logic                          Clear,
    input  logic                          Enable,
    input  logic                          Dir,
    input  logic                          Load_En,
    input  logic [$clog2(NUM_PHASES)-1:0] Load_Idx,
    output logic [NUM_PHASES-1:0]         Phase,
    output logic [$clog2(NUM_PHASES)-1:0] Phase_Index,
    output logic                          Gap_Active,
    output logic                          Wrap,
    output logic                          Illegal
);

    localparam int J    = NUM_PHASES / 2;
    localparam int IW   = $clog2(NUM_PHASES);
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_PHASES-1:0] phase_q, phase_d;
    logic                  gap_q, gap_d;
    logic                  wrap_q, wrap_d;
    logic                  ill_q, ill_d;
    logic                  step;
    logic                  load_ok;
    logic                  legal;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;

    phase_johnson_core #(
        .J  (J),
        .IW (IW)
    ) u_core (
        .clk_i      (Phase_Count),
        .clr_i      (Clear),
        .step_i     (step),
        .dir_i      (Dir),
        .load_i     (load_ok),
        .load_idx_i (Load_Idx),
        .idx_o      (idx),
        .idx_nxt_o  (idx_nxt),
        .legal_o    (legal)
    );

    // State, counter and registered outputs.
    always_ff @(posedge Phase_Count) begin
        if (Clear) begin
            state_q <= ST_PHASE;
            cnt_q   <= '0;
            phase_q <= NUM_PHASES'(1);
            gap_q   <= 1'b0;
            wrap_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            wrap_q  <= wrap_d;
            ill_q   <= ill_d;
        end
    end

    // Next state: recovery, then load, then enabled hold/gap counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        load_ok = Load_En && (int'(Load_Idx) < NUM_PHASES);
        if (!legal || load_ok) begin
            state_d = ST_PHASE;
            cnt_d   = '0;
        end else if (Enable) begin
            unique case (state_q)
                ST_PHASE: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (GAP_CYCLES > 0) state_d = ST_GAP;
                        else                step    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_d   = '0;
                        step    = 1'b1;
                        state_d = ST_PHASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_PHASE;
            endcase
        end
    end

    // Output decode from the state and index that will hold after the edge.
    always_comb begin
        phase_d = '0;
        if (state_d == ST_PHASE) phase_d[idx_nxt] = 1'b1;
        gap_d  = (state_d == ST_GAP);
        ill_d  = !legal;
        wrap_d = legal && !load_ok && step &&
                 (Dir ? (idx == '0) : (idx == IW'(NUM_PHASES - 1)));
    end

    assign Phase       = phase_q;
    assign Phase_Index = idx;
    assign Gap_Active  = gap_q;
    assign Wrap        = wrap_q;
    assign Illegal     = ill_q;

endmodule
